// File: rtl/uart_host.sv
// 32-bit word <-> 8N1 serial link, 4 bytes MSB-byte first, BITCYC clocks per bit.
// TX start bit follows accept by one cycle, tx_ready low until word and gap finish; rx_valid one cycle after last stop sample.
module uart_host #(
  parameter int BITCYC   = 1,
  parameter int WORD_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        txd,
  input  logic        rxd,
  output logic [31:0] rx_word,
  output logic        rx_valid,
  output logic        rx_frame_err,
  output logic        tx_busy
);

  localparam logic [7:0]  BIT_LAST = 8'(BITCYC - 1);
  localparam logic [7:0]  BIT_MID  = 8'((BITCYC - 1) / 2);
  localparam logic [15:0] GAP_LAST = 16'(WORD_GAP - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  tx_state_t   tx_state, tx_next;
  logic [7:0]  tx_cyc;
  logic [2:0]  tx_bit;
  logic [1:0]  tx_byte;
  logic [15:0] tx_gap;
  logic [31:0] tx_sh;
  logic [7:0]  tx_cur;
  logic        tx_bit_end;

  assign tx_bit_end = (tx_cyc == BIT_LAST);
  assign tx_cur     = tx_sh[31:24];

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_valid) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_byte != 2'd3)    tx_next = TX_START;
          else if (WORD_GAP == 0) tx_next = TX_IDLE;
          else                    tx_next = TX_GAP;
        end
      end
      TX_GAP:   if (tx_gap == GAP_LAST) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Outputs are forced to their reset values combinationally so they hold while rst is high.
  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_cur[tx_bit];
      default:  txd = 1'b1;
    endcase
    if (rst) txd = 1'b1;
    tx_ready = (tx_state == TX_IDLE) && !rst;
    tx_busy  = (tx_state != TX_IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cyc  <= '0;
      tx_bit  <= '0;
      tx_byte <= '0;
      tx_gap  <= '0;
      tx_sh   <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_state == TX_GAP || tx_bit_end) tx_cyc <= '0;
      else                                                         tx_cyc <= tx_cyc + 8'd1;
      if (tx_state == TX_DATA && tx_bit_end) tx_bit <= tx_bit + 3'd1;
      if (tx_state == TX_STOP && tx_bit_end) begin
        tx_byte <= tx_byte + 2'd1;
        tx_sh   <= {tx_sh[23:0], 8'h00};
      end
      tx_gap <= (tx_state == TX_GAP) ? tx_gap + 16'd1 : 16'd0;
      if (tx_state == TX_IDLE && tx_valid) begin
        tx_sh   <= tx_word;
        tx_byte <= '0;
        tx_bit  <= '0;
      end
    end
  end

  rx_state_t   rx_state, rx_next;
  logic [7:0]  rx_cyc;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic [1:0]  rx_slot;
  logic [23:0] rx_acc;
  logic [31:0] rx_word_q;
  logic        rx_valid_q, rx_err_q;
  logic        rx_mid, rx_end;

  assign rx_mid = (rx_cyc == BIT_MID);
  assign rx_end = (rx_cyc == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // The falling edge is cycle 0 of the start bit; with one cycle per bit it is also its sample.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rxd) rx_next = (BITCYC == 1) ? RX_DATA : RX_START;
      RX_START: begin
        if (rx_mid && rxd) rx_next = RX_IDLE;
        else if (rx_end)   rx_next = RX_DATA;
      end
      RX_DATA:   if (rx_end && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:   if (rx_mid) rx_next = rxd ? RX_IDLE : RX_WAITHI;
      RX_WAITHI: if (rxd) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cyc     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_slot    <= '0;
      rx_acc     <= '0;
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cyc <= (BITCYC == 1) ? 8'd0 : 8'd1;
          rx_bit <= '0;
        end
        RX_START, RX_DATA, RX_STOP: rx_cyc <= rx_end ? 8'd0 : rx_cyc + 8'd1;
        default: rx_cyc <= '0;
      endcase
      if (rx_state == RX_DATA && rx_mid) rx_sh  <= {rxd, rx_sh[7:1]};
      if (rx_state == RX_DATA && rx_end) rx_bit <= rx_bit + 3'd1;
      if (rx_state == RX_STOP && rx_mid) begin
        if (rxd) begin
          rx_slot <= rx_slot + 2'd1;
          rx_acc  <= {rx_acc[15:0], rx_sh};
          if (rx_slot == 2'd3) begin
            rx_word_q  <= {rx_acc, rx_sh};
            rx_valid_q <= 1'b1;
          end
        end else begin
          rx_slot  <= '0;
          rx_err_q <= 1'b1;
        end
      end
    end
  end

  assign rx_valid     = rx_valid_q && !rst;
  assign rx_frame_err = rx_err_q && !rst;
  assign rx_word      = rst ? 32'h0 : rx_word_q;

endmodule

// File: tb/tb_uart_host.sv
// Two instances: u0 (1 clk/bit, no gap, switchable loopback) and u1 (4 clk/bit, 3-cycle gap, loopback with glitch).
// Expected txd/rx words/frame errors are queued at stimulus time and checked by negedge monitors.
module tb_uart_host;
  localparam int B0 = 1, G0 = 0, B1 = 4, G1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] tx_word0, rx_word0, tx_word1, rx_word1;
  logic tx_valid0, tx_ready0, txd0, rxd0, rxd0_drv, loop0, rx_valid0, ferr0, busy0;
  logic tx_valid1, tx_ready1, txd1, rxd1, glitch1, rx_valid1, ferr1, busy1;

  assign rxd0 = loop0 ? txd0 : rxd0_drv;
  assign rxd1 = txd1 & glitch1;

  uart_host #(.BITCYC(B0), .WORD_GAP(G0)) u0 (
    .clk(clk), .rst(rst), .tx_word(tx_word0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .txd(txd0), .rxd(rxd0), .rx_word(rx_word0), .rx_valid(rx_valid0),
    .rx_frame_err(ferr0), .tx_busy(busy0));

  uart_host #(.BITCYC(B1), .WORD_GAP(G1)) u1 (
    .clk(clk), .rst(rst), .tx_word(tx_word1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .txd(txd1), .rxd(rxd1), .rx_word(rx_word1), .rx_valid(rx_valid1),
    .rx_frame_err(ferr1), .tx_busy(busy1));

  int n_chk = 0, n_pass = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Line level 'off' cycles after the first start-bit cycle of a word: 40 bits of b cycles, then idle high.
  function automatic logic exp_txd(input logic [31:0] w, input int off, input int b);
    int bi, k;
    logic [7:0] v;
    bi = off / b;
    k  = bi % 10;
    if (bi >= 40) return 1'b1;
    v = w[31 - 8 * (bi / 10) -: 8];
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return v[k - 1];
  endfunction

  typedef struct {
    logic [31:0] w;
    int          t;
  } exp_t;

  exp_t txq0[$], txq1[$], rxq0[$], rxq1[$];
  int ferrq0[$];
  logic [31:0] last0 = '0, last1 = '0;

  always @(negedge clk) begin
    exp_t e;
    int off;
    if (rst) begin
      chk1("rst_txd0", txd0, 1'b1);
      chk1("rst_tx_ready0", tx_ready0, 1'b0);
      chk1("rst_tx_busy0", busy0, 1'b0);
      chk1("rst_rx_valid0", rx_valid0, 1'b0);
      chk1("rst_frame_err0", ferr0, 1'b0);
      chk32("rst_rx_word0", rx_word0, 32'h0);
      txq0.delete();
      last0 = '0;
    end else begin
      if (txq0.size() != 0) begin
        off = cyc - txq0[0].t - 1;
        chk1("tx0_txd", txd0, exp_txd(txq0[0].w, off, B0));
        chk1("tx0_ready_low", tx_ready0, 1'b0);
        chk1("tx0_busy", busy0, 1'b1);
        if (off == 40 * B0 + G0 - 1) e = txq0.pop_front();
      end else begin
        chk1("tx0_idle_txd", txd0, 1'b1);
        chk1("tx0_idle_ready", tx_ready0, 1'b1);
        chk1("tx0_idle_busy", busy0, 1'b0);
      end
      if (tx_valid0 && tx_ready0) begin
        e.w = tx_word0;
        e.t = cyc;
        txq0.push_back(e);
        if (loop0) begin
          e.t = cyc + 39 * B0 + (B0 - 1) / 2 + 2;
          rxq0.push_back(e);
        end
      end
      if (rx_valid0) begin
        if (rxq0.size() == 0) chk1("rx0_spurious_valid", rx_valid0, 1'b0);
        else begin
          e = rxq0.pop_front();
          chk32("rx0_word", rx_word0, e.w);
          chk32("rx0_time", cyc, e.t);
          last0 = e.w;
        end
      end else chk32("rx0_hold", rx_word0, last0);
      if (ferr0) begin
        if (ferrq0.size() == 0) chk1("rx0_spurious_frame_err", ferr0, 1'b0);
        else chk32("rx0_frame_err_time", cyc, ferrq0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int off;
    if (rst) begin
      chk1("rst_txd1", txd1, 1'b1);
      chk1("rst_tx_ready1", tx_ready1, 1'b0);
      chk1("rst_rx_valid1", rx_valid1, 1'b0);
      chk32("rst_rx_word1", rx_word1, 32'h0);
      txq1.delete();
      last1 = '0;
    end else begin
      if (txq1.size() != 0) begin
        off = cyc - txq1[0].t - 1;
        chk1("tx1_txd", txd1, exp_txd(txq1[0].w, off, B1));
        chk1("tx1_ready_low", tx_ready1, 1'b0);
        chk1("tx1_busy", busy1, 1'b1);
        if (off == 40 * B1 + G1 - 1) e = txq1.pop_front();
      end else begin
        chk1("tx1_idle_txd", txd1, 1'b1);
        chk1("tx1_idle_ready", tx_ready1, 1'b1);
        chk1("tx1_idle_busy", busy1, 1'b0);
      end
      if (tx_valid1 && tx_ready1) begin
        e.w = tx_word1;
        e.t = cyc;
        txq1.push_back(e);
        e.t = cyc + 39 * B1 + (B1 - 1) / 2 + 2;
        rxq1.push_back(e);
      end
      if (rx_valid1) begin
        if (rxq1.size() == 0) chk1("rx1_spurious_valid", rx_valid1, 1'b0);
        else begin
          e = rxq1.pop_front();
          chk32("rx1_word", rx_word1, e.w);
          chk32("rx1_time", cyc, e.t);
          last1 = e.w;
        end
      end else chk32("rx1_hold", rx_word1, last1);
      chk1("rx1_no_frame_err", ferr1, 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tx0_send(input logic [31:0] w, output int ac);
    logic acc;
    int n;
    acc = 1'b0; n = 0; ac = -1;
    tx_word0 = w;
    tx_valid0 = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk); acc = tx_ready0; ac = cyc;
      @(posedge clk); #1; n++;
    end
    tx_valid0 = 1'b0;
    chk1("tx0_accept_in_time", acc, 1'b1);
  endtask

  task automatic tx1_wait();
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    while (!acc && n < 1000) begin
      @(negedge clk); acc = tx_ready1;
      @(posedge clk); #1; n++;
    end
    chk1("tx1_accept_in_time", acc, 1'b1);
  endtask

  task automatic tx1_pair(input logic [31:0] a, input logic [31:0] b);
    tx_word1 = a; tx_valid1 = 1'b1;
    tx1_wait();
    tx_word1 = b;
    tx1_wait();
    tx_valid1 = 1'b0;
  endtask

  task automatic rx0_byte(input logic [7:0] b, input logic stopb, output int s);
    s = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) s = cyc;
      rxd0_drv = (k == 0) ? 1'b0 : (k == 9) ? stopb : b[k - 1];
    end
  endtask

  task automatic rx0_level(input logic v, input int n);
    repeat (n) begin @(posedge clk); #1; rxd0_drv = v; end
  endtask

  task automatic rx0_word(input logic [31:0] w, input int mid_gap);
    int s;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 2 && mid_gap > 0) rx0_level(1'b1, mid_gap);
      rx0_byte(w[31 - 8 * i -: 8], 1'b1, s);
    end
    e.w = w;
    e.t = s + 10;
    rxq0.push_back(e);
  endtask

  initial begin
    int ac, ac2, s, rel;
    tx_word0 = '0; tx_valid0 = 1'b0; rxd0_drv = 1'b1; loop0 = 1'b0;
    tx_word1 = '0; tx_valid1 = 1'b0; glitch1 = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    rel = cyc;
    tx0_send(32'h12345678, ac);
    chk32("first_accept_after_reset", ac, rel);
    tick(45);

    loop0 = 1'b1;
    tx0_send(32'hDEADBEEF, ac);
    tx0_send(32'h00000001, ac2);
    chk32("back_to_back_accept_spacing", ac2 - ac, 41);
    for (int i = 0; i < 6; i++) begin
      tx0_send($urandom, ac);
      tick($urandom_range(0, 3) * $urandom_range(0, 5));
    end
    tick(50);
    loop0 = 1'b0;
    tick(3);

    rx0_byte(8'h5A, 1'b1, s);
    rx0_byte(8'hC3, 1'b0, s);
    ferrq0.push_back(s + 10);
    rx0_level(1'b0, 5);
    rx0_level(1'b1, 3);
    rx0_word(32'hCAFEF00D, 0);
    rx0_level(1'b1, 2);
    for (int i = 0; i < 4; i++) begin
      rx0_word($urandom, $urandom_range(0, 6));
      rx0_level(1'b1, $urandom_range(0, 3));
    end
    tick(5);

    fork
      tx0_send(32'h0BADF00D, ac);
      begin rx0_byte(8'h11, 1'b1, s); rx0_byte(8'h22, 1'b1, s); end
    join
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rel = cyc;
    fork
      tx0_send(32'h600DCAFE, ac);
      rx0_word(32'h13579BDF, 0);
    join
    chk32("accept_after_midop_reset", ac, rel);
    tick(60);

    tick(2);
    glitch1 = 1'b0;
    tick(1);
    glitch1 = 1'b1;
    tick(10);
    tx1_pair(32'hA5A5005A, $urandom);
    tx1_pair($urandom, $urandom);
    tick(400);

    chk32("rx0_queue_drained", rxq0.size(), 0);
    chk32("rx1_queue_drained", rxq1.size(), 0);
    chk32("frame_err_queue_drained", ferrq0.size(), 0);
    chk32("tx0_queue_drained", txq0.size(), 0);
    chk32("tx1_queue_drained", txq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
